// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO.
//  - default data/address widths
//  - FSM state encoding for the transmit launcher
package uart_tx_fifo_pkg;

    localparam int DBIT_DEF = 8;
    localparam int ABIT_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_regfile.sv
// fifo_regfile: 2**ABIT x DBIT storage array for the transmit FIFO.
// Ports:
//  clk     in   clock, write on rising edge
//  we      in   write enable
//  w_addr  in   write address (ABIT)
//  w_data  in   write data (DBIT)
//  r_addr  in   read address (ABIT)
//  r_data  out  combinational read of the entry at r_addr (DBIT)
module fifo_regfile #(
    parameter int DBIT = 8,
    parameter int ABIT = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ABIT-1:0] w_addr,
    input  logic [DBIT-1:0] w_data,
    input  logic [ABIT-1:0] r_addr,
    output logic [DBIT-1:0] r_data
);

    logic [DBIT-1:0] mem [2**ABIT];

    // Contents need no reset: the count/flag logic never exposes a stale entry.
    always_ff @(posedge clk) begin
        if (we)
            mem[w_addr] <= w_data;
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte buffer in front of a UART transmitter.
// Bytes written on wr are queued; one tx_start is issued per byte and the
// next byte waits for the transmitter's tx_done_tick.
// Ports:
//  clk           in   system clock
//  reset         in   synchronous, active-high
//  wr            in   write strobe
//  w_data        in   byte to queue (DBIT)
//  tx_done_tick  in   transmitter finished the current byte
//  tx_start      out  one-cycle launch pulse
//  tx_data       out  byte in flight, held until the next launch (DBIT)
//  full          out  FIFO holds 2**ABIT bytes
//  empty         out  FIFO holds no bytes
//  overflow      out  sticky: a write was dropped while full
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DBIT = DBIT_DEF,
    parameter int ABIT = ABIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] w_data,
    input  logic            tx_done_tick,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    output logic            full,
    output logic            empty,
    output logic            overflow
);

    localparam int DEPTH = 2**ABIT;

    tx_state_t       state;
    logic [ABIT-1:0] wr_ptr, rd_ptr;
    logic [ABIT:0]   count, count_next;
    logic [DBIT-1:0] rd_data;
    logic            push, pop;

    // full is the registered flag, so a write in the same cycle as a pop
    // from a full FIFO is still dropped.
    assign push = wr && !full;
    assign pop  = (state == ST_IDLE) && !empty;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    fifo_regfile #(.DBIT(DBIT), .ABIT(ABIT)) u_regfile (
        .clk    (clk),
        .we     (push),
        .w_addr (wr_ptr),
        .w_data (w_data),
        .r_addr (rd_ptr),
        .r_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            count <= count_next;
            full  <= (count_next == DEPTH[ABIT:0]);
            empty <= (count_next == '0);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (wr && full)
                overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        tx_start <= 1'b1;
                        tx_data  <= rd_data;
                        rd_ptr   <= rd_ptr + 1'b1;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    tx_start <= 1'b0;
                    if (tx_done_tick)
                        state <= ST_IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
